if_id_stage: RTL

Fetch-response and IF/ID pipeline-register stage, directly downstream of the PC unit in the 5-stage MIPS pipeline. Takes the current PC and instructionEnable and issues a word read to a synchronous instruction memory (1-cycle read latency). Registers the returned instruction with its PC into the IF/ID register that feeds decode. A 1-entry skid buffer ensures a response arriving during a decode stall is never lost; branch flush squashes wrong-path fetches.

---
 rtl/if_id_stage_pkg.sv | 42 ++++
 rtl/if_id_stage_if.sv | 21 ++
 rtl/if_id_stage_fetch_skid_buf.sv | 36 +++
 rtl/if_id_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared pipeline constants and types for the fetch-response / IF/ID stage.
// Holds the bubble encoding, stall-vector bit positions and the IF/ID update selector.
package if_id_stage_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam int          IMEM_ADDR_W = 30;

   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_BUBBLE = 2'd1,
      IFID_LOAD   = 2'd2
   } ifid_op_t;

   // Decode must never see a response while IF/ID is held, and a bubble always
   // wins over a response when the IF side is stalled or the path is wrong.
   function automatic ifid_op_t ifid_select(input logic [STALL_W-1:0] stall,
                                            input logic flush,
                                            input logic resp_valid);
      ifid_op_t op;
      if (stall[STALL_IF] && stall[STALL_ID])
         op = IFID_HOLD;
      else if (stall[STALL_IF] || flush || !resp_valid)
         op = IFID_BUBBLE;
      else
         op = IFID_LOAD;
      return op;
   endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous single-cycle-latency instruction memory (slave).
interface if_id_stage_if #(
   parameter int IMEM_AW = if_id_stage_pkg::IMEM_ADDR_W
);
   logic [IMEM_AW-1:0] imemAddress;
   logic               imemReadEnable;
   logic [31:0]        imemData;

   modport master (
      output imemAddress,
      output imemReadEnable,
      input  imemData
   );

   modport slave (
      input  imemAddress,
      input  imemReadEnable,
      output imemData
   );
endinterface

// File: rtl/if_id_stage_fetch_skid_buf.sv
// One-entry skid register that parks a fetch response arriving while IF/ID
// cannot accept it; flush discards the parked entry.
module if_id_stage_fetch_skid_buf
   import if_id_stage_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         capture,
   input  logic         drain,
   input  fetch_entry_t din,
   output logic         valid,
   output fetch_entry_t dout
);

   logic         valid_reg;
   fetch_entry_t entry_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= 1'b0;
         entry_reg <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (capture) begin
         valid_reg <= 1'b1;
         entry_reg <= din;
      end else if (drain) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign dout  = entry_reg;

endmodule

// File: rtl/if_id_stage.sv
// Fetch issue, response capture and IF/ID pipeline register. A response that
// meets an IF/ID stall is parked in the skid buffer and replayed in order.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] NOP     = NOP_INSTR,
   parameter int          IMEM_AW = IMEM_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        pc,
   input  logic               instructionEnable,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   if_id_stage_if.master      imem,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_instruction,
   output logic               id_valid
);

   logic         read_en;
   logic         req_valid_reg;
   logic [31:0]  req_pc_reg;
   logic         skid_valid;
   fetch_entry_t skid_entry;
   fetch_entry_t req_entry;
   fetch_entry_t resp_entry;
   logic         resp_valid;
   logic         skid_capture;
   logic         skid_drain;
   ifid_op_t     ifid_op;

   logic [31:0]  id_pc_reg, id_pc_next;
   logic [31:0]  id_instr_reg, id_instr_next;
   logic         id_valid_reg, id_valid_next;

   // Reset is folded in so no strobe escapes while the pipeline is held in reset.
   assign read_en             = instructionEnable & ~stall[STALL_PC] & ~flush & ~reset;
   assign imem.imemReadEnable = read_en;
   assign imem.imemAddress    = pc[IMEM_AW+1:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_valid_reg <= 1'b0;
         req_pc_reg    <= '0;
      end else begin
         req_valid_reg <= read_en;
         req_pc_reg    <= pc;
      end
   end

   assign req_entry  = '{pc: req_pc_reg, instr: imem.imemData};
   assign resp_valid = skid_valid | req_valid_reg;
   assign resp_entry = skid_valid ? skid_entry : req_entry;
   assign ifid_op    = ifid_select(stall, flush, resp_valid);

   assign skid_capture = req_valid_reg & ~skid_valid & stall[STALL_IF];
   assign skid_drain   = skid_valid & (ifid_op == IFID_LOAD);

   if_id_stage_fetch_skid_buf u_skid (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .capture (skid_capture),
      .drain   (skid_drain),
      .din     (req_entry),
      .valid   (skid_valid),
      .dout    (skid_entry)
   );

   // A bubble keeps the old PC so decode-side exception logic still sees a sane value.
   always_comb begin
      id_pc_next    = id_pc_reg;
      id_instr_next = id_instr_reg;
      id_valid_next = id_valid_reg;
      case (ifid_op)
         IFID_LOAD: begin
            id_pc_next    = resp_entry.pc;
            id_instr_next = resp_entry.instr;
            id_valid_next = 1'b1;
         end
         IFID_BUBBLE: begin
            id_instr_next = NOP;
            id_valid_next = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_pc_reg    <= '0;
         id_instr_reg <= NOP;
         id_valid_reg <= 1'b0;
      end else begin
         id_pc_reg    <= id_pc_next;
         id_instr_reg <= id_instr_next;
         id_valid_reg <= id_valid_next;
      end
   end

   assign id_pc          = id_pc_reg;
   assign id_instruction = id_instr_reg;
   assign id_valid       = id_valid_reg;

   // pc[1:0] and the downstream stall bits are intentionally not consumed here.
   logic unused_bits;
   assign unused_bits = ^{pc[1:0], stall[STALL_WB:STALL_EX]};

   // A single skid entry suffices only if IF is stalled whenever IF/ID is.
   a_skid_overflow : assert property (@(posedge clk) disable iff (reset)
      !(req_valid_reg && skid_valid && stall[STALL_IF]));
   a_stall_monotonic : assert property (@(posedge clk) disable iff (reset)
      !(stall[STALL_IF] && !stall[STALL_PC]));

endmodule
